// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, FSM states,
// datapath mux selects and branch funct3 codes.
package mc_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_LUI       = 4'd12
  } state_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch decision from funct3 and ALU flags; unknown funct3 codes never branch.
module branch_cond
  import mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = neg;
      F3_BGE:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing with
// ready-handshaked memory stages and a per-access wait watchdog.
module multicycle_main_controller
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       old_pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              hold_q;
  logic              mem_state, expire, taken;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .neg    (neg),
    .taken  (taken)
  );

  // hold_q marks the first cycle after reset so every output reads 0 even in FETCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
    end
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
  assign expire    = !hold_q && mem_state && !mem_ready &&
                     (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || hold_q || expire || (state_d != state_q))
      wait_q <= '0;
    else if (mem_state && !mem_ready)
      wait_q <= wait_q + 1'b1;
    else
      wait_q <= '0;
  end

  always_comb begin
    state_d = state_q;
    if (!hold_q) begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_d = S_DECODE;
                     else if (expire) state_d = S_FETCH;
        S_DECODE: begin
          case (op)
            OP_R:    state_d = S_EXEC_R;
            OP_I:    state_d = S_EXEC_I;
            OP_LW,
            OP_S:    state_d = S_MEM_ADR;
            OP_B:    state_d = S_BRANCH;
            OP_JAL:  state_d = S_JAL;
            OP_JALR: state_d = S_JALR;
            OP_LUI:  state_d = S_LUI;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM_ADR:   state_d = (op == OP_S) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
                     else if (expire) state_d = S_FETCH;
        S_MEM_WRITE: if (mem_ready || expire) state_d = S_FETCH;
        S_EXEC_R,
        S_EXEC_I:    state_d = S_ALU_WB;
        default:     state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    old_pc_write = 1'b0;
    adr_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    imm_src      = IMM_I;
    result_src   = RES_ALUOUT;
    illegal_op   = 1'b0;
    mem_timeout  = expire;
    if (!hold_q) begin
      case (state_q)
        S_FETCH: begin
          mem_read     = 1'b1;
          alu_src_b    = SRCB_FOUR;
          ir_write     = mem_ready;
          pc_write     = mem_ready;
          old_pc_write = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_IMM;
          imm_src    = IMM_B;
          illegal_op = !op_supported(op);
        end
        S_MEM_ADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_S) ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALU_RTYPE;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ITYPE;
        end
        S_ALU_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALU_SUB;
          pc_write  = taken;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALU;
          reg_write  = 1'b1;
          pc_write   = 1'b1;
        end
        S_LUI: begin
          imm_src    = IMM_U;
          result_src = RES_IMM;
          reg_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Scenario bench for multicycle_main_controller: tasks push per-cycle expected output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_main_controller;

  localparam int W = 24;
  localparam logic [W-1:0] PCW   = 24'h800000;
  localparam logic [W-1:0] OPCW  = 24'h400000;
  localparam logic [W-1:0] IRW   = 24'h040000;
  localparam logic [W-1:0] IMMS  = 24'h000100;
  localparam logic [W-1:0] ILL   = 24'h000020;
  localparam logic [W-1:0] TMO   = 24'h000010;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011, B_OP = 7'b1100011, JAL_OP = 7'b1101111;
  localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0, neg = 1'b0, mem_ready = 1'b0;
  logic       pc_write, old_pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       illegal_op, mem_timeout;
  logic [3:0] state_dbg;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           errors = 0;
  int           checks = 0;

  multicycle_main_controller #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .pc_write(pc_write), .old_pc_write(old_pc_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .result_src(result_src), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  wire [W-1:0] obs = {pc_write, old_pc_write, adr_src, mem_read, mem_write, ir_write,
                      reg_write, alu_src_a, alu_src_b, alu_op, imm_src, result_src,
                      illegal_op, mem_timeout, state_dbg};

  // Moore outputs of each state, straight from the state table.
  function automatic logic [W-1:0] base(input int st);
    logic [W-1:0] v;
    v = '0;
    v[3:0] = st[3:0];
    case (st)
      0:  begin v[20] = 1'b1; v[14:13] = 2'b10; end
      1:  begin v[16:15] = 2'b01; v[14:13] = 2'b01; v[10:8] = 3'b010; end
      2:  begin v[16:15] = 2'b10; v[14:13] = 2'b01; end
      3:  begin v[20] = 1'b1; v[21] = 1'b1; end
      4:  begin v[7:6] = 2'b01; v[17] = 1'b1; end
      5:  begin v[19] = 1'b1; v[21] = 1'b1; end
      6:  begin v[16:15] = 2'b10; v[12:11] = 2'b10; end
      7:  begin v[16:15] = 2'b10; v[14:13] = 2'b01; v[12:11] = 2'b11; end
      8:  v[17] = 1'b1;
      9:  begin v[16:15] = 2'b10; v[12:11] = 2'b01; end
      10: begin v[16:15] = 2'b01; v[14:13] = 2'b10; v[17] = 1'b1; v[23] = 1'b1; end
      11: begin v[16:15] = 2'b10; v[14:13] = 2'b01; v[7:6] = 2'b10;
                v[17] = 1'b1; v[23] = 1'b1; end
      12: begin v[10:8] = 3'b100; v[7:6] = 2'b11; v[17] = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Scoreboard monitor: one expectation per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", t, obs, e, $time);
      end
    end
  end

  task automatic cyc(input logic [W-1:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits, input logic [6:0] opc);
    op = opc;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      cyc(base(0), "fetch_wait");
    end
    mem_ready = 1'b1;
    cyc(base(0) | PCW | OPCW | IRW, "fetch_done");
  endtask

  task automatic test_reset;
    rst = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state_dbg !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    cyc('0, "reset_outputs");
    rst = 1'b1;
    cyc('0, "reset_release");
  endtask

  task automatic run_alu(input int fw, input logic rtype);
    do_fetch(fw, rtype ? R_OP : I_OP);
    mem_ready = 1'($urandom_range(0, 1));
    cyc(base(1), "decode");
    cyc(base(rtype ? 6 : 7), rtype ? "exec_r" : "exec_i");
    cyc(base(8), "alu_wb");
  endtask

  task automatic run_lw(input int fw, input int mw);
    do_fetch(fw, LW_OP);
    cyc(base(1), "decode");
    cyc(base(2), "mem_adr_lw");
    for (int i = 0; i < mw; i++) begin
      mem_ready = 1'b0;
      cyc(base(3), "mem_read_wait");
    end
    mem_ready = 1'b1;
    cyc(base(3), "mem_read_done");
    cyc(base(4), "mem_wb");
  endtask

  task automatic run_sw(input int fw, input int mw, input logic stuck);
    do_fetch(fw, S_OP);
    cyc(base(1), "decode");
    cyc(base(2) | IMMS, "mem_adr_s");
    if (stuck) begin
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(base(5), "mem_write_wait");
      cyc(base(5) | TMO, "mem_write_timeout");
    end else begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        cyc(base(5), "mem_write_wait");
      end
      mem_ready = 1'b1;
      cyc(base(5), "mem_write_done");
    end
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic z, input logic n,
                            input logic tk);
    do_fetch(0, B_OP);
    funct3 = f3; zero = z; neg = n;
    cyc(base(1), "decode");
    cyc(base(9) | (tk ? PCW : '0), "branch");
  endtask

  task automatic run_jump(input int kind);
    do_fetch(0, (kind == 0) ? JAL_OP : (kind == 1) ? JALR_OP : LUI_OP);
    cyc(base(1), "decode");
    cyc(base(10 + kind), (kind == 0) ? "jal" : (kind == 1) ? "jalr" : "lui");
  endtask

  task automatic test_rtype;
    run_alu(0, 1'b1);
    run_alu(1, 1'b0);
  endtask

  task automatic test_lw;
    run_lw(0, 3);
  endtask

  task automatic test_branch;
    run_branch(3'b001, 1'b0, 1'b0, 1'b1);
    run_branch(3'b000, 1'b0, 1'b0, 1'b0);
    run_branch(3'b010, 1'b1, 1'b1, 1'b0);
    run_branch(3'b000, 1'b1, 1'b0, 1'b1);
    run_branch(3'b100, 1'b0, 1'b1, 1'b1);
    run_branch(3'b101, 1'b0, 1'b1, 1'b0);
    run_branch(3'b101, 1'b0, 1'b0, 1'b1);
    run_branch(3'b111, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_jumps;
    for (int k = 0; k < 3; k++) run_jump(k);
  endtask

  task automatic test_illegal;
    do_fetch(0, 7'b1111111);
    cyc(base(1) | ILL, "illegal_decode");
    mem_ready = 1'b0;
    cyc(base(0), "illegal_back_to_fetch");
  endtask

  task automatic test_timeout;
    run_sw(0, 0, 1'b1);
    mem_ready = 1'b0;
    cyc(base(0), "after_timeout_fetch");
    run_sw(0, 3, 1'b0);
    op = R_OP;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(base(0), "fetch_stall");
    cyc(base(0) | TMO, "fetch_timeout");
    cyc(base(0), "fetch_after_timeout");
  endtask

  task automatic test_reset_mid;
    do_fetch(0, LW_OP);
    cyc(base(1), "decode");
    cyc(base(2), "mem_adr_lw");
    mem_ready = 1'b0;
    cyc(base(3), "mem_read_wait");
    rst = 1'b0;
    mem_ready = 1'b1;
    cyc(base(3), "mem_read_reset_edge");
    cyc('0, "mid_reset_outputs");
    rst = 1'b1;
    cyc('0, "mid_reset_release");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 5))
        0: run_alu($urandom_range(0, 3), 1'b1);
        1: run_alu($urandom_range(0, 3), 1'b0);
        2: run_lw($urandom_range(0, 3), $urandom_range(0, 3));
        3: run_sw($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        4: run_jump($urandom_range(0, 2));
        default: run_branch(3'b001, 1'b1, 1'b0, 1'b0);
      endcase
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_lw;
    test_branch;
    test_jumps;
    test_illegal;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
